bus_region_decoder: RTL and testbench



---
 rtl/bus_region_decoder.sv | 194 +++++++++++++++++++
 tb/tb_bus_region_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_region_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bus_region_decoder
// Purpose  : Registered 68000-style bus decoder. Matches the CPU address
//            against a base/mask region table (index 0 highest priority),
//            drives one-hot chip selects, and returns DTACK after a
//            per-region wait-state count. Unmapped accesses are terminated
//            after TIMEOUT cycles.
//            Optional feature macro: BUS_REGION_DECODER_BERR_EN
//              defined   -> unmapped timeout terminates with BERR
//              undefined -> unmapped timeout terminates with DTACK
//                           (open bus); berr_n tied high.
// Revision : 1.0 - initial release
// ============================================================================
module bus_region_decoder #(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [NUM_REGIONS*ADDR_W-1:0]                          region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0]                          region_mask,
    input  logic [NUM_REGIONS*WAIT_W-1:0]                          region_wait,
    input  logic [NUM_REGIONS-1:0]                                 region_en,
    input  logic [ADDR_W-1:0]                                      addr,
    input  logic                                                   as_n,
    output logic [NUM_REGIONS-1:0]                                 cs,
    output logic [((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] hit_idx,
    output logic                                                   multi_hit,
    output logic                                                   unmapped,
    output logic                                                   dtack_n,
    output logic                                                   berr_n
);

    localparam int IDX_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TCNT_W-1:0]      c_TMO_LOAD = TCNT_W'(TIMEOUT - 1);
    localparam logic [NUM_REGIONS-1:0] c_ONE      = NUM_REGIONS'(1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_WAIT = 3'd1;
    localparam logic [2:0] c_ACK  = 3'd2;
    localparam logic [2:0] c_TMO  = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;

    logic [NUM_REGIONS-1:0] w_match;
    logic [NUM_REGIONS-1:0] w_win_onehot;
    logic                   w_any_match;
    logic                   w_multi;
    logic [IDX_W-1:0]       w_win_idx;
    logic [WAIT_W-1:0]      w_win_wait;

    logic [2:0]             r_state;
    logic [NUM_REGIONS-1:0] r_cs;
    logic [IDX_W-1:0]       r_hit_idx;
    logic                   r_multi_hit;
    logic                   r_unmapped;
    logic                   r_dtack_n;
    logic [WAIT_W-1:0]      r_wcnt;
    logic [TCNT_W-1:0]      r_tcnt;
`ifdef BUS_REGION_DECODER_BERR_EN
    logic                   r_berr_n;
`endif

    // Per-region base/mask compare, gated by the region enable
    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_match
            assign w_match[gi] = region_en[gi] &
                ((addr & region_mask[gi*ADDR_W +: ADDR_W]) ==
                 (region_base[gi*ADDR_W +: ADDR_W] & region_mask[gi*ADDR_W +: ADDR_W]));
        end
    endgenerate

    // Lowest set bit is the winner; a second set bit means an overlap
    assign w_win_onehot = w_match & (~w_match + c_ONE);
    assign w_any_match  = |w_match;
    assign w_multi      = |(w_match & (w_match - c_ONE));

    // Priority encode the winner index and its wait count (low index wins)
    always_comb begin
        w_win_idx  = '0;
        w_win_wait = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_win_idx  = IDX_W'(i);
                w_win_wait = region_wait[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // Access sequencer: decode is latched only in IDLE, then counted out
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cs        <= '0;
            r_hit_idx   <= '0;
            r_multi_hit <= 1'b0;
            r_unmapped  <= 1'b0;
            r_dtack_n   <= 1'b1;
            r_wcnt      <= '0;
            r_tcnt      <= '0;
`ifdef BUS_REGION_DECODER_BERR_EN
            r_berr_n    <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!as_n) begin
                        if (w_any_match) begin
                            r_cs        <= w_win_onehot;
                            r_hit_idx   <= w_win_idx;
                            r_multi_hit <= w_multi;
                            r_wcnt      <= w_win_wait;
                            r_state     <= c_WAIT;
                        end else begin
                            r_unmapped  <= 1'b1;
                            r_tcnt      <= c_TMO_LOAD;
                            r_state     <= c_TMO;
                        end
                    end
                end
                c_WAIT: begin
                    if (as_n) begin
                        // Strobe withdrawn before DTACK: abandon quietly
                        r_cs        <= '0;
                        r_hit_idx   <= '0;
                        r_multi_hit <= 1'b0;
                        r_unmapped  <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (r_wcnt == '0) begin
                        r_dtack_n   <= 1'b0;
                        r_state     <= c_ACK;
                    end else begin
                        r_wcnt      <= r_wcnt - 1'b1;
                    end
                end
                c_ACK: begin
                    if (as_n) begin
                        r_cs        <= '0;
                        r_hit_idx   <= '0;
                        r_multi_hit <= 1'b0;
                        r_dtack_n   <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                c_TMO: begin
                    if (as_n) begin
                        r_unmapped  <= 1'b0;
                        r_state     <= c_IDLE;
                    end else if (r_tcnt == '0) begin
`ifdef BUS_REGION_DECODER_BERR_EN
                        r_berr_n    <= 1'b0;
`else
                        r_dtack_n   <= 1'b0;
`endif
                        r_state     <= c_ERR;
                    end else begin
                        r_tcnt      <= r_tcnt - 1'b1;
                    end
                end
                c_ERR: begin
                    if (as_n) begin
`ifdef BUS_REGION_DECODER_BERR_EN
                        r_berr_n    <= 1'b1;
`else
                        r_dtack_n   <= 1'b1;
`endif
                        r_unmapped  <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cs        = r_cs;
    assign hit_idx   = r_hit_idx;
    assign multi_hit = r_multi_hit;
    assign unmapped  = r_unmapped;
    assign dtack_n   = r_dtack_n;
`ifdef BUS_REGION_DECODER_BERR_EN
    assign berr_n    = r_berr_n;
`else
    assign berr_n    = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_region_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_region_decoder
// Purpose  : Self-checking bench for bus_region_decoder: directed vector
//            table, reset corner sequences, and randomized accesses checked
//            against a transaction-level timeline model.
//            Honours BUS_REGION_DECODER_BERR_EN for termination style.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_region_decoder;

    localparam int NR = 16;
    localparam int AW = 24;
    localparam int WW = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] region_base;
    logic [NR*AW-1:0] region_mask;
    logic [NR*WW-1:0] region_wait;
    logic [NR-1:0]    region_en;
    logic [AW-1:0]    addr;
    logic             as_n;
    logic [NR-1:0]    cs;
    logic [3:0]       hit_idx;
    logic             multi_hit;
    logic             unmapped;
    logic             dtack_n;
    logic             berr_n;

    int n_checks = 0;
    int n_pass   = 0;

    bus_region_decoder #(
        .NUM_REGIONS (NR),
        .ADDR_W      (AW),
        .WAIT_W      (WW),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .region_base (region_base),
        .region_mask (region_mask),
        .region_wait (region_wait),
        .region_en   (region_en),
        .addr        (addr),
        .as_n        (as_n),
        .cs          (cs),
        .hit_idx     (hit_idx),
        .multi_hit   (multi_hit),
        .unmapped    (unmapped),
        .dtack_n     (dtack_n),
        .berr_n      (berr_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        int          hold;
        logic [15:0] ecs;
        logic [3:0]  eidx;
        logic        emulti;
        logic        eunm;
        int          tj;
    } vec_t;

    vec_t vecs [10];

    // Compare all outputs at once; hit_idx is optionally ignored
    task automatic check_out(input string name, input logic [15:0] ecs, input logic [3:0] eidx,
                             input bit idx_care, input bit emulti, input bit eunm,
                             input bit edtack, input bit eberr);
        logic [23:0] act;
        logic [23:0] exp;
        logic [23:0] msk;
        act = {cs, hit_idx, multi_hit, unmapped, dtack_n, berr_n};
        exp = {ecs, eidx, emulti, eunm, edtack, eberr};
        msk = idx_care ? 24'hFFFFFF : 24'hFFFF0F;
        n_checks++;
        if ((act & msk) == (exp & msk)) n_pass++;
        else $display("FAIL %s: got {cs,idx,multi,unm,dtack_n,berr_n}=%h expected %h (mask %h)",
                      name, act, exp, msk);
    endtask

    task automatic check_idle(input string name);
        check_out(name, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic set_region(input int i, input logic [23:0] b, input logic [23:0] m,
                              input logic [3:0] w, input bit en);
        region_base[i*AW +: AW] = b;
        region_mask[i*AW +: AW] = m;
        region_wait[i*WW +: WW] = w;
        region_en[i]            = en;
    endtask

    // Reference decode: first enabled match wins; termination step is
    // 1+wait after the strobe edge for a hit, TIMEOUT for a miss.
    function automatic void ref_decode(input logic [23:0] a, output logic [15:0] ecs,
                                       output logic [3:0] eidx, output logic emulti,
                                       output logic eunm, output int tj);
        int cnt;
        int win;
        logic [23:0] b;
        logic [23:0] m;
        logic [3:0]  w;
        cnt = 0;
        win = -1;
        for (int i = 0; i < NR; i++) begin
            b = region_base[i*AW +: AW];
            m = region_mask[i*AW +: AW];
            if (region_en[i] && ((a & m) == (b & m))) begin
                cnt++;
                if (win < 0) win = i;
            end
        end
        if (win < 0) begin
            ecs = '0; eidx = '0; emulti = 1'b0; eunm = 1'b1; tj = TO;
        end else begin
            w      = region_wait[win*WW +: WW];
            ecs    = 16'h0001 << win;
            eidx   = win[3:0];
            emulti = (cnt >= 2);
            eunm   = 1'b0;
            tj     = 1 + int'(w);
        end
    endfunction

    // One access: strobe held for 'hold' edges, then 'gap' idle edges.
    // Address and wait table are disturbed mid-access to prove they are
    // only sampled at the strobe edge.
    task automatic run_access(input string name, input logic [23:0] a, input int hold,
                              input int gap, input logic [15:0] ecs, input logic [3:0] eidx,
                              input logic emulti, input logic eunm, input int tj);
        logic [NR*WW-1:0] saved_wait;
        logic [31:0]      r32;
        bit               term;
        bit               edt;
        bit               ebe;
        saved_wait = region_wait;
        addr = a;
        as_n = 1'b0;
        for (int j = 0; j < hold; j++) begin
            @(posedge clk); #1;
            term = (j >= tj);
            edt  = 1'b1;
            ebe  = 1'b1;
            if (!eunm) edt = !term;
            else begin
`ifdef BUS_REGION_DECODER_BERR_EN
                ebe = !term;
`else
                edt = !term;
`endif
            end
            check_out($sformatf("%s step%0d", name, j), ecs, eidx, !eunm, emulti, eunm, edt, ebe);
            if (j == 0) begin
                r32 = $urandom;
                addr = a ^ r32[23:0] ^ 24'h800000;
                region_wait = ~saved_wait;
            end
        end
        as_n = 1'b1;
        region_wait = saved_wait;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            check_idle($sformatf("%s idle%0d", name, g));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ecs;
        logic [3:0]  eidx;
        logic        emulti;
        logic        eunm;
        int          tj;
        int          hold;
        int          r;
        logic [31:0] r32;
        logic [23:0] a;
        logic [23:0] bb;
        logic [23:0] mm;

        reset = 1'b1; as_n = 1'b1; addr = '0;
        region_base = '0; region_mask = '0; region_wait = '0; region_en = '0;

        // Directed table
        set_region(0, 24'h000000, 24'hFC0000, 4'd0,  1'b1);
        set_region(1, 24'h070000, 24'hFFC000, 4'd3,  1'b1);
        set_region(2, 24'h0E0000, 24'hFFFF00, 4'd1,  1'b1);
        set_region(3, 24'h100000, 24'hFF0000, 4'd15, 1'b1);
        set_region(5, 24'h0E0000, 24'hFF0000, 4'd2,  1'b1);

        vecs[0] = '{24'h012344, 4,  16'h0001, 4'd0, 1'b0, 1'b0, 1};
        vecs[1] = '{24'h073FFE, 6,  16'h0002, 4'd1, 1'b0, 1'b0, 4};
        vecs[2] = '{24'h0E0040, 4,  16'h0004, 4'd2, 1'b1, 1'b0, 2};
        vecs[3] = '{24'h0C0000, 18, 16'h0000, 4'd0, 1'b0, 1'b1, 16};
        vecs[4] = '{24'h0C0000, 5,  16'h0000, 4'd0, 1'b0, 1'b1, 16};
        vecs[5] = '{24'h073FFE, 4,  16'h0002, 4'd1, 1'b0, 1'b0, 4};
        vecs[6] = '{24'h012344, 1,  16'h0001, 4'd0, 1'b0, 1'b0, 1};
        vecs[7] = '{24'h10ABCD, 5,  16'h0008, 4'd3, 1'b0, 1'b0, 16};
        vecs[8] = '{24'h10ABCD, 18, 16'h0008, 4'd3, 1'b0, 1'b0, 16};
        vecs[9] = '{24'h0C0000, 17, 16'h0000, 4'd0, 1'b0, 1'b1, 16};

        repeat (3) @(posedge clk);
        #1 check_out("reset state", 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1 check_idle("after reset");

        for (int v = 0; v < 10; v++) begin
            run_access($sformatf("vec%0d", v), vecs[v].addr, vecs[v].hold, 1 + (v % 2),
                       vecs[v].ecs, vecs[v].eidx, vecs[v].emulti, vecs[v].eunm, vecs[v].tj);
        end

        // Reset during ACK with the strobe still low
        addr = 24'h012344; as_n = 1'b0;
        @(posedge clk); #1 check_out("rstack cs", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1 check_out("rstack dtack", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 check_out("rstack reset", 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0; as_n = 1'b1;
        @(posedge clk); #1 check_out("rstack no redecode", 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        as_n = 1'b0;
        @(posedge clk); #1 check_out("rstack redecode", 16'h0001, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        as_n = 1'b1;
        @(posedge clk); #1 check_idle("rstack abort");

        // Reset during a long WAIT
        addr = 24'h10ABCD; as_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_out("rstwait mid", 16'h0008, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1 check_out("rstwait reset", 16'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        reset = 1'b0; as_n = 1'b1;
        @(posedge clk); #1 check_idle("rstwait idle");

        // Randomized tables and accesses
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < NR; i++) begin
                r32 = $urandom;
                bb  = r32[23:0];
                r   = int'($urandom_range(8, 20));
                mm  = 24'hFFFFFF << r;
                r32 = $urandom;
                set_region(i, bb, mm, r32[3:0], r32[4] | r32[5]);
            end
            // Overlap: region 7 is a superset of region 3
            region_base[7*AW +: AW] = region_base[3*AW +: AW];
            region_mask[7*AW +: AW] = region_mask[3*AW +: AW] << 2;
            for (int t = 0; t < 40; t++) begin
                r32 = $urandom;
                if (r32[1:0] != 2'b11) begin
                    r  = int'($urandom_range(0, NR - 1));
                    bb = region_base[r*AW +: AW];
                    mm = region_mask[r*AW +: AW];
                    r32 = $urandom;
                    a  = (bb & mm) | (r32[23:0] & ~mm);
                end else begin
                    r32 = $urandom;
                    a   = r32[23:0];
                end
                ref_decode(a, ecs, eidx, emulti, eunm, tj);
                hold = int'($urandom_range(1, tj + 4));
                run_access($sformatf("rnd%0d.%0d", ph, t), a, hold,
                           int'($urandom_range(1, 3)), ecs, eidx, emulti, eunm, tj);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
